div_repsub: RTL and testbench



---
 rtl/div_repsub_if.sv | 23 ++
 rtl/div_repsub.sv | 101 ++++++++++
 tb/tb_div_repsub.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_repsub_if.sv
// Start/done handshake bundle for the repeated-subtraction divider.
// The operand bus carries the dividend, then the divisor on the next cycle.
interface div_repsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, data_in,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, data_in,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_repsub.sv
// Sequential unsigned divider: quotient/remainder by repeated subtraction,
// one subtraction per clock while the working remainder is at least the divisor.
module div_repsub #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    div_repsub_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LDA,
        LDB,
        SUB,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] q_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] diff;
    logic             r_ge_b;
    logic             b_zero;

    assign diff   = r_q - b_q;
    assign r_ge_b = (r_q >= b_q);
    assign b_zero = (b_q == '0);

    // busy/done are registered alongside the state so they change on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r_q    <= '0;
            b_q    <= '0;
            q_q    <= '0;
            dz_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= LDA;
                        busy_q <= 1'b1;
                    end
                end
                LDA: begin
                    r_q   <= bus.data_in;
                    state <= LDB;
                end
                LDB: begin
                    b_q   <= bus.data_in;
                    q_q   <= '0;
                    dz_q  <= 1'b0;
                    state <= SUB;
                end
                SUB: begin
                    if (b_zero) begin
                        dz_q   <= 1'b1;
                        q_q    <= '1;
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (r_ge_b) begin
                        r_q <= diff;
                        q_q <= q_q + WIDTH'(1);
                    end else begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state  <= LDA;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q;
    assign bus.div_by_zero = dz_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: directed corner cases plus random
// operands checked against a plain-arithmetic reference of quotient/remainder/latency.
module tb_div_repsub;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    div_repsub_if #(.WIDTH(16)) bus ();

    div_repsub #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result and the edge index at which done must first be seen.
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic dz, output int lat);
        if (b == 16'd0) begin
            q = 16'hFFFF; r = a; dz = 1'b1; lat = 3;
        end else begin
            q = a / b; r = a % b; dz = 1'b0; lat = 3 + int'(a / b);
        end
    endfunction

    // Stimulus only: issue start, present operands, count edges until done (bounded).
    task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                          input int budget, output int lat);
        int n;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.data_in = a;
        @(posedge clk); #1;
        bus.data_in = b;
        @(posedge clk); #1;
        bus.data_in = 16'h0;
        n = 2;
        while (!bus.done && n < budget) begin
            @(posedge clk); n++; #1;
        end
        lat = n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dz=%b, want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_start: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed(input logic [15:0] a, input logic [15:0] b, input string name);
        int lat, elat;
        logic [15:0] eq, er;
        logic edz;
        ref_div(a, b, eq, er, edz, elat);
        do_div(a, b, elat + 10, lat);
        vectors++;
        if (lat !== elat || bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_latency: got E%0d done=%b, want E%0d", name, lat, bus.done, elat);
        end
        vectors++;
        if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edz || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_result: got q=%h r=%h dz=%b busy=%b, want q=%h r=%h dz=%b busy=0",
                     name, bus.quotient, bus.remainder, bus.div_by_zero, bus.busy, eq, er, edz);
        end
    endtask

    task automatic test_done_hold();
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (bus.done !== 1'b1 || bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
            miscompares++;
            $display("FAIL done_hold: got done=%b q=%0d r=%0d, want done=1 q=14 r=2",
                     bus.done, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.data_in = 16'd200;
        @(posedge clk); #1;
        bus.data_in = 16'd10;
        @(posedge clk); #1;
        n = 2;
        repeat (5) begin @(posedge clk); n++; #1; end
        bus.start = 1'b1;
        @(posedge clk); n++; #1;
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_sub: got busy=%b, want 1", bus.busy);
        end
        while (!bus.done && n < 40) begin @(posedge clk); n++; #1; end
        vectors++;
        if (n !== 23 || bus.quotient !== 16'd20 || bus.remainder !== 16'd0 || bus.div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_sub_result: got E%0d q=%0d r=%0d dz=%b, want E23 q=20 r=0 dz=0",
                     n, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.start = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.quotient !== 16'd20) begin
            miscompares++;
            $display("FAIL restart_edge: got done=%b busy=%b q=%0d, want done=0 busy=1 q=20 (held)",
                     bus.done, bus.busy, bus.quotient);
        end
        bus.data_in = 16'd9;
        @(posedge clk); #1;
        bus.data_in = 16'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 2;
        while (!bus.done && n < 20) begin @(posedge clk); n++; #1; end
        vectors++;
        if (n !== 5 || bus.quotient !== 16'd2 || bus.remainder !== 16'd1) begin
            miscompares++;
            $display("FAIL back_to_back: got E%0d q=%0d r=%0d, want E5 q=2 r=1",
                     n, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.data_in = 16'd1000;
        @(posedge clk); #1;
        bus.data_in = 16'd3;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_mid_sub: got q=%h r=%h busy=%b done=%b dz=%b, want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_div(16'd8, 16'd2, 20, lat);
        vectors++;
        if (lat !== 7 || bus.quotient !== 16'd4 || bus.remainder !== 16'd0) begin
            miscompares++;
            $display("FAIL after_reset: got E%0d q=%0d r=%0d, want E7 q=4 r=0",
                     lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, eq, er;
        logic edz;
        int lat, elat;
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0: begin a = 16'($urandom); b = 16'($urandom_range(512, 65535)); end
                1: begin a = 16'($urandom_range(0, 1023)); b = 16'($urandom_range(1, 64)); end
                default: begin a = 16'($urandom); b = (i % 6 == 2) ? 16'd0 : 16'($urandom_range(1024, 65535)); end
            endcase
            ref_div(a, b, eq, er, edz, elat);
            do_div(a, b, elat + 10, lat);
            vectors++;
            if (lat !== elat || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edz) begin
                miscompares++;
                $display("FAIL random_%0d (%h/%h): got E%0d q=%h r=%h dz=%b, want E%0d q=%h r=%h dz=%b",
                         i, a, b, lat, bus.quotient, bus.remainder, bus.div_by_zero,
                         elat, eq, er, edz);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = 16'h0;
        test_reset();
        test_directed(16'd100, 16'd7, "div_100_7");
        test_done_hold();
        test_directed(16'd5, 16'd9, "div_5_9");
        test_directed(16'h1234, 16'h0, "div_by_zero");
        test_directed(16'd0, 16'd5, "div_0_5");
        test_directed(16'hFFFF, 16'hFFFF, "div_max_max");
        test_directed(16'hFFFF, 16'd1, "div_max_1");
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
